// File: rtl/ffchk_pkg.sv
// Shared types and constants for the flip-flop output checker.
package ffchk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    CHECK,
    DONE
  } state_t;

  localparam logic [7:0] FIRST_NONE = 8'hFF;

endpackage

// File: rtl/delay_line.sv
// DEPTH-stage shift register; q is d as sampled DEPTH rising edges earlier.
module delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] taps;

  // NOTE: non-blocking so each tap takes its neighbour's pre-edge value; a
  // blocking chain would collapse the whole line into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps <= (taps << 1) | DEPTH'(d);
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/ff_output_checker.sv
// Compares two devices' outputs against a delayed copy of their common input
// over a window of num_cycles clocks and reports mismatch statistics.
module ff_output_checker
  import ffchk_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       num_cycles,
  input  logic             d,
  input  logic             q_a,
  input  logic             q_b,
  output logic             busy,
  output logic             done,
  output logic             err_a,
  output logic             err_b,
  output logic [CNT_W-1:0] mis_cnt_a,
  output logic [CNT_W-1:0] mis_cnt_b,
  output logic             diverge,
  output logic [7:0]       first_err_cyc
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       WARM_END = 3'(LATENCY - 1);

  state_t     state;
  logic [7:0] n_lat;
  logic [7:0] idx;
  logic [2:0] warm;
  logic       exp_q;
  logic       mis_a;
  logic       mis_b;

  delay_line #(.DEPTH(LATENCY)) u_delay_line (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (exp_q)
  );

  assign mis_a = q_a ^ exp_q;
  assign mis_b = q_b ^ exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      n_lat         <= '0;
      idx           <= '0;
      warm          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_a         <= 1'b0;
      err_b         <= 1'b0;
      mis_cnt_a     <= '0;
      mis_cnt_b     <= '0;
      diverge       <= 1'b0;
      first_err_cyc <= FIRST_NONE;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= WARMUP;
            busy          <= 1'b1;
            n_lat         <= num_cycles;
            idx           <= '0;
            warm          <= '0;
            err_a         <= 1'b0;
            err_b         <= 1'b0;
            mis_cnt_a     <= '0;
            mis_cnt_b     <= '0;
            diverge       <= 1'b0;
            first_err_cyc <= FIRST_NONE;
          end
        end
        WARMUP: begin
          // Wait until the delay line holds the first in-window sample.
          if (warm == WARM_END) begin
            if (n_lat == 8'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end else begin
            warm <= warm + 3'd1;
          end
        end
        CHECK: begin
          if (mis_a) begin
            err_a <= 1'b1;
            if (mis_cnt_a != CNT_MAX) mis_cnt_a <= mis_cnt_a + CNT_W'(1);
          end
          if (mis_b) begin
            err_b <= 1'b1;
            if (mis_cnt_b != CNT_MAX) mis_cnt_b <= mis_cnt_b + CNT_W'(1);
          end
          // The sticky flags are still clear only on the window's first mismatch.
          if ((mis_a || mis_b) && !err_a && !err_b) first_err_cyc <= idx;
          if (q_a != q_b) diverge <= 1'b1;
          idx <= idx + 8'd1;
          if (idx == n_lat - 8'd1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff_output_checker.sv
// Bench for ff_output_checker: three instances (LATENCY/CNT_W variants) share
// stimulus; each is compared every cycle against a window-level model.
module tb_ff_output_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_cycles = 8'd0;
  logic       d = 1'b0;
  logic       d_reg = 1'b0;
  logic       flip_b = 1'b0;
  logic       d_tog = 1'b1;
  int         qa_mode = 0;   // 0: correct flop, 1: zero-delay wire, 2: inverted flop
  bit         chk_en = 1'b0;

  int errors = 0;
  int checks = 0;

  logic        busy_v[3];
  logic        done_v[3];
  logic        ea_v[3];
  logic        eb_v[3];
  logic        div_v[3];
  logic [15:0] mca_v[3];
  logic [15:0] mcb_v[3];
  logic [7:0]  first_v[3];

  always #5 clk = ~clk;

  // Reference device under check: a plain one-cycle flop fed by d.
  always @(posedge clk) d_reg <= d;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (d_tog) d = ~d;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int IDX  = g;
    localparam int L    = (g == 2) ? 3 : 1;
    localparam int CW   = (g == 1) ? 4 : 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          qa, qb, busy, done, err_a, err_b, diverge;
    logic [CW-1:0] mca, mcb;
    logic [7:0]    first;

    assign qa = (qa_mode == 1) ? d : (qa_mode == 2) ? ~d_reg : d_reg;
    assign qb = d_reg ^ flip_b;

    ff_output_checker #(.LATENCY(L), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .num_cycles    (num_cycles),
      .d             (d),
      .q_a           (qa),
      .q_b           (qb),
      .busy          (busy),
      .done          (done),
      .err_a         (err_a),
      .err_b         (err_b),
      .mis_cnt_a     (mca),
      .mis_cnt_b     (mcb),
      .diverge       (diverge),
      .first_err_cyc (first)
    );

    assign busy_v[g]  = busy;
    assign done_v[g]  = done;
    assign ea_v[g]    = err_a;
    assign eb_v[g]    = err_b;
    assign div_v[g]   = diverge;
    assign mca_v[g]   = 16'(mca);
    assign mcb_v[g]   = 16'(mcb);
    assign first_v[g] = first;

    // Model: rel counts edges since the accepting edge; compares happen on
    // edges L+1 .. L+n, done follows edge L+n, IDLE again after edge L+n+1.
    bit act = 0, m_busy = 0, m_done = 0, m_ea = 0, m_eb = 0, m_div = 0, e;
    int rel = 0, n = 0, ca = 0, cb = 0, first_m = 255;
    bit dh[$];

    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        dh.delete();
        act = 0; rel = 0; n = 0; ca = 0; cb = 0; first_m = 255;
        m_busy = 0; m_done = 0; m_ea = 0; m_eb = 0; m_div = 0;
      end else begin
        e = (dh.size() >= L) ? dh[L-1] : 1'b0;
        if (act) begin
          rel++;
          if (rel > L && rel <= L + n) begin
            if ((qa != e || qb != e) && !m_ea && !m_eb) first_m = rel - L - 1;
            if (qa != e) begin m_ea = 1; if (ca < CMAX) ca++; end
            if (qb != e) begin m_eb = 1; if (cb < CMAX) cb++; end
            if (qa != qb) m_div = 1;
          end
          m_busy = (rel < L + n);
          m_done = (rel == L + n);
          if (rel > L + n) act = 0;
        end else if (start) begin
          act = 1; rel = 0; n = int'(num_cycles);
          ca = 0; cb = 0; first_m = 255; m_ea = 0; m_eb = 0; m_div = 0;
          m_busy = 1; m_done = 0;
        end else begin
          m_busy = 0; m_done = 0;
        end
        dh.push_front(d);
        if (dh.size() > 8) void'(dh.pop_back());
      end
    end

    initial forever begin
      @(negedge clk);
      if (chk_en) begin
        check($sformatf("i%0d busy", IDX),      busy,    m_busy);
        check($sformatf("i%0d done", IDX),      done,    m_done);
        check($sformatf("i%0d err_a", IDX),     err_a,   m_ea);
        check($sformatf("i%0d err_b", IDX),     err_b,   m_eb);
        check($sformatf("i%0d diverge", IDX),   diverge, m_div);
        check($sformatf("i%0d mis_cnt_a", IDX), mca,     ca);
        check($sformatf("i%0d mis_cnt_b", IDX), mcb,     cb);
        check($sformatf("i%0d first_err", IDX), first,   first_m);
      end
    end
  end

  // k = negedges after the accepting edge at which done is first seen high;
  // done in cycle s+L+N+1 means k = L+N.
  task automatic run_window(input int nc, input int idx, output int k, output int bcnt);
    tick();
    start = 1'b1;
    num_cycles = 8'(nc);
    tick();
    start = 1'b0;
    k = 0;
    bcnt = 0;
    while (!done_v[idx] && k < 600) begin
      if (busy_v[idx]) bcnt++;
      tick();
      k++;
    end
  endtask

  task automatic settle();
    repeat (5) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k, bcnt, dcount;

    repeat (3) tick();
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    check("reset busy",  busy_v[0],  0);
    check("reset done",  done_v[0],  0);
    check("reset first", first_v[0], 255);
    check("reset cnt_a", mca_v[0],   0);

    // Matched devices, d toggling, 20 compares.
    qa_mode = 0;
    run_window(20, 0, k, bcnt);
    check("s1 done offset", k, 21);
    check("s1 busy cycles", bcnt, 21);
    settle();
    check("s1 cnt_a", mca_v[0], 0);
    check("s1 cnt_b", mcb_v[0], 0);
    check("s1 err_a", ea_v[0], 0);
    check("s1 diverge", div_v[0], 0);
    check("s1 first", first_v[0], 255);

    // Device A collapsed to a wire: every compare mismatches on A only.
    qa_mode = 1;
    run_window(10, 0, k, bcnt);
    check("s2 done offset", k, 11);
    settle();
    check("s2 cnt_a", mca_v[0], 10);
    check("s2 cnt_b", mcb_v[0], 0);
    check("s2 err_a", ea_v[0], 1);
    check("s2 err_b", eb_v[0], 0);
    check("s2 diverge", div_v[0], 1);
    check("s2 first", first_v[0], 0);

    // Inverted A for 30 compares: 4-bit counter saturates.
    qa_mode = 2;
    run_window(30, 1, k, bcnt);
    check("s3 done offset", k, 31);
    settle();
    check("s3 cnt_a sat", mca_v[1], 15);
    check("s3 err_a", ea_v[1], 1);
    check("s3 cnt_a wide", mca_v[0], 30);

    // Zero-length window on LATENCY=3.
    qa_mode = 0;
    run_window(0, 2, k, bcnt);
    check("s4 done offset", k, 3);
    check("s4 busy cycles", bcnt, 3);
    settle();
    check("s4 cnt_a", mca_v[2], 0);
    check("s4 first", first_v[2], 255);

    // Single B flip at index 7, ignored start and num_cycles change mid-window.
    tick();
    start = 1'b1;
    num_cycles = 8'd20;
    tick();
    start = 1'b0;
    k = 0;
    while (!done_v[0] && k < 600) begin
      tick();
      k++;
      flip_b = (k == 8);
      start = (k == 12);
      if (k == 12) num_cycles = 8'd3;
    end
    check("s5 done offset", k, 21);
    settle();
    check("s5 first", first_v[0], 7);
    check("s5 cnt_b", mcb_v[0], 1);
    check("s5 cnt_a", mca_v[0], 0);
    check("s5 idle", busy_v[0], 0);

    // Reset in the middle of a window.
    qa_mode = 2;
    tick();
    start = 1'b1;
    num_cycles = 8'd20;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("s6 pre-reset cnt_a", mca_v[0], 5);
    #2 rst_n = 1'b0;
    #1;
    check("s6 rst busy",  busy_v[0],  0);
    check("s6 rst done",  done_v[0],  0);
    check("s6 rst cnt_a", mca_v[0],   0);
    check("s6 rst err_a", ea_v[0],    0);
    check("s6 rst first", first_v[0], 255);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_v[0] || done_v[1] || done_v[2]) dcount++;
    end
    check("s6 no done after reset", dcount, 0);
    qa_mode = 0;
    run_window(5, 0, k, bcnt);
    check("s6 fresh done offset", k, 6);
    settle();
    check("s6 fresh cnt_a", mca_v[0], 0);
    check("s6 fresh first", first_v[0], 255);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ff_output_checker.md
FF_OUTPUT_CHECKER -- requirements
Module: ff_output_checker

Interface
REQ-001 SHALL have parameter LATENCY, default 1, expected d-to-q delay in clocks, legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 8, mismatch counter width, legal range 4..16.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a check window; sampled only in IDLE.
REQ-007 num_cycles  input  8  number of compare cycles; latched when start is accepted.
REQ-008 d  input  1  stimulus bit also driven into both devices under check.
REQ-009 q_a  input  1  output of device A.
REQ-010 q_b  input  1  output of device B.
REQ-011 busy  output  1  high in WARMUP and CHECK.
REQ-012 done  output  1  one-cycle pulse in DONE.
REQ-013 err_a, err_b  output  1 each  sticky: at least one mismatch on that channel in the current window.
REQ-014 mis_cnt_a, mis_cnt_b  output  CNT_W each  mismatch counts.
REQ-015 diverge  output  1  sticky: q_a != q_b on at least one compare cycle.
REQ-016 first_err_cyc  output  8  compare index of first mismatch on either channel; 8'hFF = none.

Function
REQ-017 SHALL sample d every clock, in every state, into a LATENCY-deep delay line; exp = d sampled LATENCY edges earlier.
REQ-018 FSM states SHALL be IDLE, WARMUP, CHECK, DONE.
REQ-019 IDLE: start=1 at edge s -> WARMUP; latch num_cycles; clear counters, sticky flags and compare index; set first_err_cyc to 8'hFF.
REQ-020 WARMUP SHALL last exactly LATENCY cycles, then -> CHECK, or -> DONE if the latched num_cycles=0.
REQ-021 CHECK: every edge SHALL compare q_a vs exp and q_b vs exp, then increment the compare index; after the N-th compare -> DONE.
REQ-022 done SHALL be high exactly in cycle s+LATENCY+N+1; DONE -> IDLE unconditionally.
REQ-023 mis_cnt_x SHALL increment by 1 per mismatch and saturate at all-ones (no wrap).
REQ-024 first_err_cyc SHALL capture the compare index (0-based) on the first mismatch of either channel only; later mismatches leave it unchanged.
REQ-025 diverge SHALL set only on CHECK cycles where q_a != q_b.
REQ-026 start outside IDLE SHALL be ignored; num_cycles changes after latch SHALL have no effect.
REQ-027 All results SHALL hold their values from DONE until the next accepted start.
REQ-028 q_a/q_b SHALL be treated as synchronous to clk; no internal synchronizers.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, clear the delay line, set busy/done/err_a/err_b/diverge to 0 and mis_cnt_a/mis_cnt_b to 0, and set first_err_cyc to 8'hFF.
REQ-030 Reset mid-window SHALL abandon the window with no done pulse; the first start after release SHALL begin a fresh window.

Structure
REQ-031 Package ffchk_pkg SHALL hold the state enumeration and constant FIRST_NONE = 8'hFF.
REQ-032 The delay line SHALL be a sub-module named delay_line (parameter DEPTH, async active-low reset).
REQ-033 Total RTL SHALL be under 400 lines.

Verification
REQ-034 LATENCY=1, q_a=q_b=d registered one cycle, d toggles every cycle, num_cycles=20 -> done at s+22; mis_cnt 0/0; err 0/0; diverge 0; first_err_cyc=FF.
REQ-035 q_a=d (zero-delay, blocking-style collapse), q_b correct, d alternating, num_cycles=10 -> mis_cnt_a=10, mis_cnt_b=0, err_a=1, diverge=1, first_err_cyc=0.
REQ-036 CNT_W=4, q_a=~exp, num_cycles=30 -> mis_cnt_a=15 (saturated), err_a=1.
REQ-037 LATENCY=3, num_cycles=0 -> busy for 3 cycles, done at s+4, all counts 0, first_err_cyc=FF.
REQ-038 Single q_b flip at compare index 7, plus start pulsed during CHECK -> first_err_cyc=7, mis_cnt_b=1, window not restarted.
REQ-039 rst_n low at compare index 5 -> all outputs at reset values, no done pulse; a new window then completes normally.
